norm_shift_lzc: RTL

- Iterative leading-zero counter and left-normalizer for the MAC datapath. It is the consumer end of zero detection: it does not just flag an all-zero vector, it counts the leading zeros and shifts them out.
- Sits after the adder, ahead of the rounding stage.
- Accepts one operand per valid/ready handshake.
- Returns the normalized mantissa, the leading-zero count and an all-zero flag after a data-dependent number of cycles.

---
 rtl/norm_shift_lzc_if.sv | 22 ++
 rtl/norm_shift_lzc.sv | 66 ++++++
 2 files changed

// File: rtl/norm_shift_lzc_if.sv
// norm_shift_lzc_if: operand handshake and normalized-result bus for norm_shift_lzc
interface norm_shift_lzc_if #(
   parameter int XLEN = 48,
   parameter int CW = $clog2(XLEN + 1)
);
   logic            in_valid_i;
   logic            in_ready_o;
   logic [XLEN-1:0] in_data_i;
   logic            out_valid_o;
   logic            out_ready_i;
   logic [XLEN-1:0] out_data_o;
   logic [CW-1:0]   out_lzc_o;
   logic            out_zero_o;
   modport master (
      output in_valid_i, in_data_i, out_ready_i,
      input  in_ready_o, out_valid_o, out_data_o, out_lzc_o, out_zero_o
   );
   modport slave (
      input  in_valid_i, in_data_i, out_ready_i,
      output in_ready_o, out_valid_o, out_data_o, out_lzc_o, out_zero_o
   );
endinterface

// File: rtl/norm_shift_lzc.sv
// norm_shift_lzc: iterative leading-zero counter and left-normalizer, STEP bits per coarse cycle
module norm_shift_lzc #(
   parameter int XLEN = 48,
   parameter int STEP = 8,
   localparam int CW = $clog2(XLEN + 1)
) (
   input logic             clk_i,
   input logic             rst_ni,
   norm_shift_lzc_if.slave bus
);
   localparam int KW = $clog2(STEP);
   localparam logic [1:0] IDLE = 2'd0, COARSE = 2'd1, FINE = 2'd2, DONE = 2'd3;
   logic [1:0]      state;
   logic [XLEN-1:0] work;
   logic [CW-1:0]   cnt;
   logic            zero;
   logic            valid;
   logic [STEP-1:0] top;
   logic [KW-1:0]   k;
   assign top             = work[XLEN-1 -: STEP];
   assign bus.in_ready_o  = state == IDLE;
   assign bus.out_valid_o = valid;
   assign bus.out_data_o  = work;
   assign bus.out_lzc_o   = cnt;
   assign bus.out_zero_o  = zero;
   // leading zeros within the top chunk; the highest set bit wins because it is visited last
   always_comb begin
      k = '0;
      for (int i = 0; i < STEP; i++) if (top[i]) k = KW'(STEP - 1 - i);
   end
   // coarse chunk skipping, one fine shift, then hold the result until it is taken
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         state <= IDLE;
         work  <= '0;
         cnt   <= '0;
         zero  <= 1'b0;
         valid <= 1'b0;
      end else case (state)
         IDLE: if (bus.in_valid_i) begin
            work  <= bus.in_data_i;
            cnt   <= '0;
            zero  <= 1'b0;
            state <= COARSE;
         end
         COARSE: if (~|work) begin
            zero  <= 1'b1;
            cnt   <= CW'(XLEN);
            work  <= '0;
            state <= DONE;
         end else if (~|top) begin
            work <= work << STEP;
            cnt  <= cnt + CW'(STEP);
         end else state <= FINE;
         FINE: begin
            work  <= work << k;
            cnt   <= cnt + CW'(k);
            state <= DONE;
         end
         default: if (!valid) valid <= 1'b1;
         else if (bus.out_ready_i) begin
            valid <= 1'b0;
            state <= IDLE;
         end
      endcase
endmodule
